// File: rtl/multi_clock_divider.sv
// N-channel programmable clock divider: per-channel tick pulse and 50%-duty divided clock.
// Optional feature: define CLKDIV_SYNC_START_EN to add the sync_start realignment input.
module multi_clock_divider #(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int DIV_DEFAULT = 2
) (
  input  logic                                    clk,
  input  logic                                    limpa_n,
`ifdef CLKDIV_SYNC_START_EN
  input  logic                                    sync_start,
`endif
  input  logic [NCH-1:0]                          en,
  input  logic                                    cfg_valid,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [W-1:0]                            cfg_div,
  output logic                                    cfg_ready,
  output logic                                    cfg_err,
  output logic [NCH-1:0]                          tick,
  output logic [NCH-1:0]                          clk_out
);

  localparam int            CHW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW:0]  NCH_L   = (CHW + 1)'(NCH);
  localparam logic [W-1:0]  DIV_RST = W'(DIV_DEFAULT);

  logic [W-1:0]   count    [NCH];
  logic [W-1:0]   div      [NCH];
  logic [W-1:0]   pend_div [NCH];
  logic [NCH-1:0] pending;

  logic ch_ok;
  logic div_ok;
  logic accept;
  logic sync_now;

  assign ch_ok  = ({1'b0, cfg_ch} < NCH_L);
  assign div_ok = (cfg_div != '0);
  assign accept = cfg_valid & cfg_ready & ch_ok & div_ok;

`ifdef CLKDIV_SYNC_START_EN
  assign sync_now = sync_start;
`else
  assign sync_now = 1'b0;
`endif

  // Out-of-range channels report ready so a bad write is always flagged.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CHW'(i)) cfg_ready = ~pending[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!limpa_n) begin
      cfg_err <= 1'b0;
      tick    <= '0;
      clk_out <= '0;
      pending <= '0;
      for (int i = 0; i < NCH; i++) begin
        count[i]    <= '0;
        div[i]      <= DIV_RST;
        pend_div[i] <= DIV_RST;
      end
    end else begin
      cfg_err <= cfg_valid & cfg_ready & ~(ch_ok & div_ok);
      for (int i = 0; i < NCH; i++) begin
        if (sync_now) begin
          count[i]   <= '0;
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
          if (pending[i]) begin
            div[i]     <= pend_div[i];
            pending[i] <= 1'b0;
          end
        end else if (en[i]) begin
          if (count[i] == div[i] - W'(1)) begin
            count[i]   <= '0;
            tick[i]    <= 1'b1;
            clk_out[i] <= ~clk_out[i];
            if (pending[i]) begin
              div[i]     <= pend_div[i];
              pending[i] <= 1'b0;
            end
          end else begin
            count[i] <= count[i] + W'(1);
            tick[i]  <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
          // A disabled channel would never reach terminal count, so apply now.
          if (pending[i]) begin
            div[i]     <= pend_div[i];
            count[i]   <= '0;
            pending[i] <= 1'b0;
          end
        end
        // Acceptance implies pending[i]==0, so it never collides with an apply above.
        if (accept && cfg_ch == CHW'(i)) begin
          pend_div[i] <= cfg_div;
          pending[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed and random stimulus against a reference model.
module tb_multi_clock_divider;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: NCH=4, W=16, DIV_DEFAULT=2
  logic       rst_n;
  logic [3:0] en;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [15:0] cfg_div;
  logic       cfg_ready, cfg_err;
  logic [3:0] tick, clk_out;

  multi_clock_divider #(.NCH(4), .W(16), .DIV_DEFAULT(2)) dut (
    .clk(clk), .limpa_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .tick(tick), .clk_out(clk_out)
  );

  // Boundary instance: NCH=3 (channel 3 is out of range), W=4, default divisor 15
  logic       b_rst_n;
  logic [2:0] b_en;
  logic       b_valid;
  logic [1:0] b_ch;
  logic [3:0] b_div;
  logic       b_ready, b_err;
  logic [2:0] b_tick, b_clk;

  multi_clock_divider #(.NCH(3), .W(4), .DIV_DEFAULT(15)) dut_b (
    .clk(clk), .limpa_n(b_rst_n), .en(b_en), .cfg_valid(b_valid), .cfg_ch(b_ch),
    .cfg_div(b_div), .cfg_ready(b_ready), .cfg_err(b_err), .tick(b_tick), .clk_out(b_clk)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: position within period, divisor, and queued divisor per channel
  int         m_pos [4];
  int         m_div [4];
  int         m_pdiv[4];
  bit         m_pend[4];
  logic [3:0] m_tick;
  logic [3:0] m_clk;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pos[i] = 0; m_div[i] = 2; m_pdiv[i] = 2; m_pend[i] = 0;
    end
    m_tick = '0; m_clk = '0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit rdy, good;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rdy  = !m_pend[cfg_ch];
    good = (cfg_div != 0);
    m_err = cfg_valid && rdy && !good;
    for (int i = 0; i < 4; i++) begin
      m_tick[i] = 1'b0;
      if (en[i]) begin
        m_pos[i] = m_pos[i] + 1;
        if (m_pos[i] >= m_div[i]) begin
          m_pos[i] = 0;
          m_tick[i] = 1'b1;
          m_clk[i] = ~m_clk[i];
          if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
        end
      end else if (m_pend[i]) begin
        m_div[i] = m_pdiv[i]; m_pos[i] = 0; m_pend[i] = 0;
      end
    end
    if (cfg_valid && rdy && good) begin
      m_pend[cfg_ch] = 1; m_pdiv[cfg_ch] = int'(cfg_div);
    end
  endtask

  // One clock: check combinational ready, advance model, check registered outputs.
  task automatic cycle();
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
    model_edge();
    @(posedge clk); #1;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("clk_out", 32'(clk_out), 32'(m_clk));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [15:0] dv);
    int n = 0;
    cfg_ch = ch; cfg_div = dv; cfg_valid = 1'b0;
    while (!m_pend[ch] == 1'b0 && n < 200) begin cycle(); n++; end
    if (n >= 200) chk("write_wait_timeout", 32'(n), 32'd0);
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 4'hF; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = 16'd1;
    b_rst_n = 1'b0; b_en = 3'b111; b_valid = 1'b0; b_ch = '0; b_div = 4'd1;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    cycle();
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);

    // Default divisor 2: first tick on the 2nd edge, all channels in phase
    rst_n = 1'b1;
    cycle();
    chk("first_edge_no_tick", 32'(tick), 32'h0);
    cycle();
    chk("second_edge_tick", 32'(tick), 32'hF);
    chk("second_edge_clk", 32'(clk_out), 32'hF);
    repeat (6) cycle();

    // Write ch1 div=5 at count 0; ready stays low until the next terminal count
    n = 0;
    while (m_pos[1] != 0 && n < 10) begin cycle(); n++; end
    cfg_ch = 2'd1; cfg_div = 16'd5; cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    chk("ch1_pending_not_ready", 32'(cfg_ready), 32'h0);
    repeat (25) cycle();

    // Rejected write: divisor zero pulses cfg_err for exactly one cycle
    cfg_ch = 2'd0; cfg_div = 16'd0; cfg_valid = 1'b1;
    cycle();
    chk("err_pulse", 32'(cfg_err), 32'h1);
    cfg_valid = 1'b0;
    cycle();
    chk("err_clears", 32'(cfg_err), 32'h0);
    repeat (6) cycle();

    // ch2 div=3, then disable at count 1 for 7 cycles and write while disabled
    write_cfg(2'd2, 16'd3);
    n = 0;
    while ((m_pend[2] || m_pos[2] != 1) && n < 20) begin cycle(); n++; end
    en[2] = 1'b0;
    repeat (7) cycle();
    en[2] = 1'b1;
    repeat (6) cycle();
    en[2] = 1'b0;
    cycle();
    write_cfg(2'd2, 16'd4);
    cycle();
    chk("disabled_apply_ready", 32'(cfg_ready), 32'h1);
    en[2] = 1'b1;
    repeat (10) cycle();

    // Reset mid-period with a pending write
    write_cfg(2'd3, 16'd7);
    rst_n = 1'b0;
    cycle();
    chk("midreset_outputs", 32'({tick, clk_out}), 32'h0);
    cfg_ch = 2'd3;
    #1 chk("midreset_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      en        = ($urandom_range(3) != 0) ? 4'hF : 4'($urandom_range(15));
      cfg_valid = ($urandom_range(4) == 0);
      cfg_ch    = 2'($urandom_range(3));
      cfg_div   = 16'($urandom_range(9));
      rst_n     = ($urandom_range(149) != 0);
      cycle();
    end
    rst_n = 1'b0; cfg_valid = 1'b0;
    cycle();

    // Boundary instance: div=15 at W=4, and out-of-range channel rejection
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      chk("w4_tick", 32'(b_tick[0]), 32'(k % 15 == 0));
      chk("w4_clk_out", 32'(b_clk[0]), 32'((k / 15) % 2));
    end
    b_ch = 2'd3; b_div = 4'd5; b_valid = 1'b1;
    #1 chk("bad_ch_ready", 32'(b_ready), 32'h1);
    @(posedge clk); #1;
    chk("bad_ch_err", 32'(b_err), 32'h1);
    b_valid = 1'b0;
    @(posedge clk); #1;
    chk("bad_ch_err_clears", 32'(b_err), 32'h0);
    for (int k = 3; k <= 15; k++) begin
      @(posedge clk); #1;
      chk("bad_ch_phase_kept", 32'(b_tick), (k == 15) ? 32'h7 : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
